// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: credit-limited word fetches to a variable-latency memory,
// in-order response buffering with PCs, and redirect flush that drops stale in-flight words.
module ifetch_buffer #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);
  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam int unsigned     CW      = PW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_after_pop;
  logic [XLEN-1:0] redirect_base;

  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Credits cover in-flight and buffered words alike, so every kept response finds a free slot.
  assign mem_req_valid   = rst && !redirect &&
                           (({1'b0, outst_q} + {1'b0, count_q}) < CREDITS);
  assign mem_req_addr    = fetch_pc_q;
  assign req_fire        = mem_req_valid && mem_req_ready;
  assign push            = mem_rsp_valid && !redirect && (drop_q == '0);
  assign out_valid       = (count_q != '0);
  assign pop             = out_valid && out_ready && !redirect;
  assign count_after_pop = count_q - CW'(pop);
  assign out_instr       = out_instr_q;
  assign out_pc          = out_pc_q;

  // NOTE: every variable gets its hold value first so no path through the block infers a latch.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    outst_d     = outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_d     = outst_q - CW'(mem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (mem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_after_pop + CW'(push);

      // The head register bypasses the array when the incoming word becomes the new head.
      if (push && (count_after_pop == '0)) begin
        out_instr_d = mem_rsp_data;
        out_pc_d    = rsp_pc_q;
      end else if (count_d != '0) begin
        out_instr_d = instr_mem[rd_ptr_d];
        out_pc_d    = pc_mem[rd_ptr_d];
      end
    end
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, independent of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= PC_INIT;
      rsp_pc_q    <= PC_INIT;
      outst_q     <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // NOTE: the storage array is not reset; count decides which entries are live and the head registers carry the reset value.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_rsp_data;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  // A kept response arriving at a full buffer means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!rst) !(push && (count_q == FULL)));

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: a latency-programmable in-order memory model feeds the
// DUT, and each phase checks hand-derived cycle-by-cycle outputs.
module tb_ifetch_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  ifetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_ready    (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hDEAD_0000;
  endfunction

  // Memory model: request accepted in cycle N returns in cycle N+lat, in order.
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] cyc     = '0;
  logic [31:0] lat     = 32'd1;
  int unsigned req_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
      end else if (mem_req_valid && mem_req_ready) begin
        mq.push_back('{addr: mem_req_addr, due: cyc + lat});
        req_cnt++;
      end
    end
  end

  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc           = cyc + 32'd1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (rst && (mq.size() != 0) && (mq[0].due == cyc)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_of(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  // Whatever sits at the head must carry the word fetched from its own PC.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid) check("instr_of_pc", {32'd0, out_instr}, {32'd0, word_of(out_pc)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Resets mid-cycle, holds across a negedge, releases just after a rising edge (cycle 0).
  task automatic start(input logic [31:0] lat_v, input logic ordy);
    rst           = 1'b0;
    lat           = lat_v;
    out_ready     = ordy;
    mem_req_ready = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    @(negedge clk);
    next_cycle();
    req_cnt = 0;
    rst     = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    out_ready     = 1'b1;
    mem_req_ready = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr",  mem_req_addr,  0);
    check("rst_out_valid", out_valid,     0);
    check("rst_out_instr", out_instr,     0);
    check("rst_out_pc",    out_pc,        0);

    // Streaming at latency 1: out_pc in cycle k is 4*(k-2)
    start(32'd1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("p1_req_valid", mem_req_valid, 1);
      check("p1_req_addr",  mem_req_addr,  64'(4 * k));
      if (k >= 2) begin
        check("p1_out_valid", out_valid, 1);
        check("p1_out_pc",    out_pc,    64'(4 * (k - 2)));
      end else begin
        check("p1_out_valid_fill", out_valid, 0);
      end
      next_cycle();
    end

    // Backpressure: four credits fill, head holds 0x0, then drains with no gaps
    start(32'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("p2_hold_valid", out_valid, 1);
        check("p2_hold_pc",    out_pc,    0);
      end
      if (k == 9) begin
        check("p2_req_blocked", mem_req_valid, 0);
        check("p2_req_count",   64'(req_cnt), 4);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("p2_drain_valid", out_valid, 1);
      check("p2_drain_pc",    out_pc,    64'(4 * j));
      next_cycle();
    end

    // Redirect with three requests in flight (latency 3)
    start(32'd3, 1'b1);
    for (int k = 0; k <= 10; k++) begin
      if (k == 3) begin
        redirect    = 1'b1;
        redirect_pc = 64'h1000;
      end
      if (k == 4) redirect = 1'b0;
      @(negedge clk);
      if (k < 3) begin
        check("p3_req_valid", mem_req_valid, 1);
        check("p3_req_addr",  mem_req_addr,  64'(4 * k));
      end else if (k == 3) begin
        check("p3_redir_req_valid", mem_req_valid, 0);
        check("p3_redir_out_valid", out_valid,     0);
      end else if (k < 8) begin
        check("p3_stale_out_valid", out_valid,     0);
        check("p3_new_req_valid",   mem_req_valid, 1);
        check("p3_new_req_addr",    mem_req_addr,  64'h1000 + 64'(4 * (k - 4)));
      end else begin
        check("p3_new_out_valid", out_valid, 1);
        check("p3_new_out_pc",    out_pc,    64'h1000 + 64'(4 * (k - 8)));
      end
      next_cycle();
    end

    // Redirect coinciding with a response and a pop (latency 2, one word left in flight)
    start(32'd2, 1'b1);
    for (int k = 0; k <= 10; k++) begin
      if (k == 5) begin
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
      end
      if (k == 6) redirect = 1'b0;
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        check("p4_pre_out_valid", out_valid, 1);
        check("p4_pre_out_pc",    out_pc,    64'(4 * (k - 3)));
      end
      if (k == 5) check("p4_redir_req_valid", mem_req_valid, 0);
      if (k == 6) begin
        check("p4_new_req_valid", mem_req_valid, 1);
        check("p4_new_req_addr",  mem_req_addr,  64'h2000);
      end
      if (k >= 6 && k <= 8) check("p4_flushed_out_valid", out_valid, 0);
      if (k >= 9) begin
        check("p4_new_out_valid", out_valid, 1);
        check("p4_new_out_pc",    out_pc,    64'h2000 + 64'(4 * (k - 9)));
      end
      next_cycle();
    end

    // Back-to-back redirects, misaligned target, address wrap
    start(32'd1, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 64'h3000;
    @(negedge clk);
    check("p5_redir0_req_valid", mem_req_valid, 0);
    next_cycle();
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    check("p5_redir1_req_valid", mem_req_valid, 0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("p5_req_valid",   mem_req_valid, 1);
    check("p5_req_aligned", mem_req_addr,  64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check("p5_req_wrap", mem_req_addr, 64'h0);
    next_cycle();
    @(negedge clk);
    check("p5_out_valid_top", out_valid, 1);
    check("p5_out_pc_top",    out_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check("p5_out_pc_wrap", out_pc, 64'h0);
    next_cycle();
    @(negedge clk);
    check("p5_out_pc_next", out_pc, 64'h4);

    // Asynchronous reset between clock edges while streaming
    #2;
    rst = 1'b0;
    #1;
    check("p6_async_out_valid", out_valid,     0);
    check("p6_async_req_valid", mem_req_valid, 0);
    check("p6_async_req_addr",  mem_req_addr,  0);
    check("p6_async_out_instr", out_instr,     0);
    check("p6_async_out_pc",    out_pc,        0);
    next_cycle();
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("p6_restart_req_addr", mem_req_addr, 64'(4 * k));
      if (k >= 2) check("p6_restart_out_pc", out_pc, 64'(4 * (k - 2)));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
